bs_cfg_receiver: RTL and testbench

BS_CFG_RECEIVER -- requirements
Module: bs_cfg_receiver

---
 rtl/bs_pkg.sv | 16 +
 rtl/bs_cfg_mem.sv | 59 +++++
 rtl/bs_cfg_receiver.sv | 107 ++++++++++
 tb/tb_bs_cfg_receiver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared bitstream definitions: FSM state encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bs_pkg;

  localparam int BS_ADDR_WIDTH = 8;
  localparam int BS_GPIO_WIDTH = 8;
  localparam int BS_NUM_BITS   = 200;

  typedef enum logic [1:0] {
    BS_IDLE = 2'd0,
    BS_LOAD = 2'd1,
    BS_DONE = 2'd2
  } bs_state_e;

endpackage

// File: rtl/bs_cfg_mem.sv
// Configuration bit storage: data flop plus written-mask flop per bit, one write port, one registered read port.
// Latency: write visible on the next edge; rd_data valid one cycle after rd_addr (sees the previous edge's write).
// Backpressure: none; a write is accepted on every cycle wr_en is high.
//
// Ports: clk/rst_n (async active-low); mask_clr clears every written flag;
// wr_en/wr_addr/wr_data write port; wr_seen = mask bit of wr_addr (combinational);
// rd_addr -> rd_data registered readback (0 beyond NUM_BITS); pad_bits = low GPIO_WIDTH data bits.
module bs_cfg_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BITS   = 200,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mask_clr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  output logic                  wr_seen,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data,
  output logic [GPIO_WIDTH-1:0] pad_bits
);

  logic [NUM_BITS-1:0] data_q;
  logic [NUM_BITS-1:0] mask_q;
  logic                rd_sel;

  // Address decode by comparison loop: addresses past NUM_BITS simply match nothing.
  always_comb begin
    rd_sel  = 1'b0;
    wr_seen = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) rd_sel  = data_q[i];
      if (wr_addr == ADDR_WIDTH'(i)) wr_seen = mask_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      mask_q  <= '0;
      rd_data <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BITS; i++) begin
        if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
          data_q[i] <= wr_data;
          mask_q[i] <= 1'b1;
        end
      end
      // Clearing wins over a same-cycle mark.
      if (mask_clr) mask_q <= '0;
      rd_data <= rd_sel;
    end
  end

  assign pad_bits = data_q[GPIO_WIDTH-1:0];

endmodule

// File: rtl/bs_cfg_receiver.sv
// Configuration bitstream receiver: loads NUM_BITS addressed bits, then drives pad input-enables from them.
// Latency: a write lands on its edge; cfg_done rises the cycle after the final distinct write; readback is 1 cycle.
// Backpressure: none; illegal writes (out of range, or while DONE) are dropped and flag sticky err.
//
// Ports: clk, rst_n (async active-low); prog_start starts/restarts a load; enable/address/data_in
// write one bit; rd_addr -> rd_data readback; IE pad enables (0 unless cfg_done);
// busy (LOAD), cfg_done (DONE), err (sticky), bits_loaded (distinct addresses written this load).
module bs_cfg_receiver
  import bs_pkg::*;
#(
  parameter int ADDR_WIDTH = BS_ADDR_WIDTH,
  parameter int NUM_BITS   = BS_NUM_BITS,
  parameter int GPIO_WIDTH = BS_GPIO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_start,
  input  logic                  enable,
  input  logic [0:ADDR_WIDTH-1] address,
  input  logic                  data_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data,
  output logic [0:GPIO_WIDTH-1] IE,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   bits_loaded
);

  localparam logic [ADDR_WIDTH:0] NUM_BITS_C = (ADDR_WIDTH+1)'(NUM_BITS);
  localparam logic [ADDR_WIDTH:0] LAST_C     = NUM_BITS_C - 1'b1;

  bs_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [GPIO_WIDTH-1:0] pad_bits;
  logic                  in_range;
  logic                  wr_ok;
  logic                  wr_seen;
  logic                  cnt_inc;
  logic                  err_set;

  // address arrives MSB-first; the packed copy keeps the numeric value.
  assign wr_addr  = address;
  assign in_range = {1'b0, wr_addr} < NUM_BITS_C;

  // prog_start always wins: any same-cycle write is dropped.
  assign wr_ok   = (state_q == BS_LOAD) && enable && !prog_start && in_range;
  assign cnt_inc = wr_ok && !wr_seen && (bits_loaded != NUM_BITS_C);
  assign err_set = !prog_start && enable &&
                   (((state_q == BS_LOAD) && !in_range) || (state_q == BS_DONE));

  bs_cfg_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BITS   (NUM_BITS),
    .GPIO_WIDTH (GPIO_WIDTH)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .mask_clr (prog_start),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (data_in),
    .wr_seen  (wr_seen),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .pad_bits (pad_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    cfg_done = 1'b0;
    IE       = '0;
    case (state_q)
      BS_LOAD: begin
        busy = 1'b1;
        // Completion is taken on the edge that records the last distinct address.
        if (cnt_inc && (bits_loaded == LAST_C)) state_d = BS_DONE;
      end
      BS_DONE: begin
        cfg_done = 1'b1;
        for (int i = 0; i < GPIO_WIDTH; i++) IE[i] = pad_bits[i];
      end
      default: ;
    endcase
    if (prog_start) state_d = BS_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_loaded <= '0;
      err         <= 1'b0;
    end else if (prog_start) begin
      bits_loaded <= '0;
      err         <= 1'b0;
    end else begin
      if (cnt_inc) bits_loaded <= bits_loaded + 1'b1;
      if (err_set) err         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bs_cfg_receiver.sv
module tb_bs_cfg_receiver;

  localparam int AW = 8;
  localparam int NB = 200;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          prog_start = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic          data_in = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data;
  logic [GW-1:0] IE;
  logic          busy;
  logic          cfg_done;
  logic          err;
  logic [AW:0]   bits_loaded;

  int   checks = 0;
  int   errors = 0;
  logic model [0:255];
  logic exp_q [$];
  int   addr_q [$];
  bit   rd_pending = 1'b0;

  bs_cfg_receiver #(.ADDR_WIDTH(AW), .NUM_BITS(NB), .GPIO_WIDTH(GW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_start  (prog_start),
    .enable      (enable),
    .address     (address),
    .data_in     (data_in),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .IE          (IE),
    .busy        (busy),
    .cfg_done    (cfg_done),
    .err         (err),
    .bits_loaded (bits_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later; retire any outstanding readback.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_pending) begin
      automatic logic e = exp_q.pop_front();
      automatic int   a = addr_q.pop_front();
      chk($sformatf("rd_data[%0d]", a), {31'b0, rd_data}, {31'b0, e});
      rd_pending = 1'b0;
    end
  endtask

  // Present a readback address; expected value is the model content at the sampling edge.
  task automatic rd_req(input int a);
    rd_addr = a[AW-1:0];
    exp_q.push_back((a < NB) ? model[a] : 1'b0);
    addr_q.push_back(a);
    rd_pending = 1'b1;
  endtask

  task automatic wr(input int a, input logic d, input bit commit);
    enable  = 1'b1;
    address = a[AW-1:0];
    data_in = d;
    tick();
    enable = 1'b0;
    if (commit) model[a] = d;
  endtask

  task automatic pstart();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, cfg_done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_bits", {23'b0, bits_loaded}, 0);
    chk("rst_ie", {24'b0, IE}, 0);
    chk("rst_rd", {31'b0, rd_data}, 0);

    // prog_start accepted on the first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    chk("start_busy", {31'b0, busy}, 1);
    chk("start_bits", {23'b0, bits_loaded}, 0);

    // Full load, data = addr[0]; read back each previous address while loading
    for (int i = 0; i < NB; i++) begin
      if (i > 0) rd_req(i - 1);
      if (i == NB - 1) begin
        chk("pre_last_bits", {23'b0, bits_loaded}, NB - 1);
        chk("pre_last_done", {31'b0, cfg_done}, 0);
        chk("pre_last_ie", {24'b0, IE}, 0);
      end
      wr(i, i[0], 1'b1);
    end
    chk("full_done", {31'b0, cfg_done}, 1);
    chk("full_busy", {31'b0, busy}, 0);
    chk("full_bits", {23'b0, bits_loaded}, NB);
    chk("full_ie", {24'b0, IE}, 32'b01010101);
    chk("full_err", {31'b0, err}, 0);

    // Write in DONE: dropped, err set, still done
    wr(3, 1'b0, 1'b0);
    chk("done_wr_err", {31'b0, err}, 1);
    chk("done_wr_done", {31'b0, cfg_done}, 1);
    chk("done_wr_ie", {24'b0, IE}, 32'b01010101);
    rd_req(3);
    tick();

    // Restart: clears count/err, keeps memory
    pstart();
    chk("restart_err", {31'b0, err}, 0);
    chk("restart_busy", {31'b0, busy}, 1);
    chk("restart_done", {31'b0, cfg_done}, 0);
    chk("restart_bits", {23'b0, bits_loaded}, 0);
    chk("restart_ie", {24'b0, IE}, 0);
    rd_req(3);
    tick();
    rd_req(4);
    tick();

    // Duplicate writes to address 5
    wr(5, 1'b1, 1'b1);
    chk("dup1_bits", {23'b0, bits_loaded}, 1);
    wr(5, 1'b0, 1'b1);
    chk("dup2_bits", {23'b0, bits_loaded}, 1);
    rd_req(5);
    tick();
    wr(5, 1'b1, 1'b1);
    chk("dup3_bits", {23'b0, bits_loaded}, 1);
    chk("dup_err", {31'b0, err}, 0);
    rd_req(5);
    tick();

    // Out-of-range write and the last legal address
    wr(250, 1'b1, 1'b0);
    chk("oor_err", {31'b0, err}, 1);
    chk("oor_bits", {23'b0, bits_loaded}, 1);
    rd_req(250);
    tick();
    rd_req(NB);
    tick();
    wr(NB - 1, 1'b0, 1'b1);
    chk("last_addr_bits", {23'b0, bits_loaded}, 2);
    chk("err_sticky", {31'b0, err}, 1);
    rd_req(NB - 1);
    tick();
    pstart();
    chk("oor_clear_err", {31'b0, err}, 0);
    chk("oor_clear_bits", {23'b0, bits_loaded}, 0);

    // prog_start collides with a write: write dropped
    prog_start = 1'b1;
    enable     = 1'b1;
    address    = '0;
    data_in    = 1'b1;
    tick();
    prog_start = 1'b0;
    enable     = 1'b0;
    chk("coll_bits", {23'b0, bits_loaded}, 0);
    chk("coll_busy", {31'b0, busy}, 1);
    chk("coll_err", {31'b0, err}, 0);
    rd_req(0);
    tick();

    // 100 writes then asynchronous reset mid-cycle
    for (int i = 0; i < 100; i++) wr(i, 1'b1, 1'b1);
    chk("part_bits", {23'b0, bits_loaded}, 100);
    rd_req(0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ie", {24'b0, IE}, 0);
    chk("arst_done", {31'b0, cfg_done}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_bits", {23'b0, bits_loaded}, 0);
    chk("arst_err", {31'b0, err}, 0);
    chk("arst_rd", {31'b0, rd_data}, 0);
    for (int i = 0; i < 256; i++) model[i] = 1'b0;
    tick();
    tick();
    chk("arst_hold_done", {31'b0, cfg_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // enable in IDLE is ignored without error
    wr(10, 1'b1, 1'b0);
    chk("idle_busy", {31'b0, busy}, 0);
    chk("idle_err", {31'b0, err}, 0);
    chk("idle_bits", {23'b0, bits_loaded}, 0);
    rd_req(10);
    tick();
    rd_req(0);
    tick();

    pstart();
    wr(0, 1'b1, 1'b1);
    chk("reload_bits", {23'b0, bits_loaded}, 1);
    rd_req(0);
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
